hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Generates the stall-select (SS) that zeroes ID-stage control signals, plus the pipeline load enables, IF/ID flush and operand forwarding selects.
- Keeps its own shadow pipeline of destination-register information for the EX, MEM and WB stages, so hazard decisions use registered state.
- Sits in the ID stage, beside the control unit and its NOP-insertion mux.

Parameters:
- REG_W, 4, register-specifier width (R0-R15).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous reset, active-low.
- id_rn  in  REG_W  ID source register Rn.
- id_rm  in  REG_W  ID source register Rm.
- id_rd  in  REG_W  ID destination register; also the store-data source.
- id_rn_used, id_rm_used, id_rd_used  in  1 each  source-read qualifiers (id_rd_used = store reads Rd).
- id_RF_enable  in  1  ID instruction writes the RF (pre-mux CU value).
- id_load_instr  in  1  ID instruction is a load (pre-mux CU value).
- id_branch_taken  in  1  branch/BL resolved taken in ID.
- mem_busy  in  1  data memory not ready; freeze the whole pipeline.
- SS  out  1  1 = insert NOP (zero ID control signals).
- LE_PC  out  1  PC load enable.
- LE_IF_ID  out  1  IF/ID load enable.
- LE_pipe  out  1  ID/EX, EX/MEM and MEM/WB load enable.
- flush_IF_ID  out  1  clear the IF/ID instruction.
- fwd_A, fwd_B, fwd_C  out  2 each  operand selects for Rn, Rm and Rd: 00 RF, 01 EX, 10 MEM, 11 WB.
- stall_count  out  CNT_W  number of load-use stall cycles, saturating.

Behaviour:
- Shadow stages EX, MEM and WB each hold {rd, rf_en, load}.
- Reset (async, rst_n=0):
  - All shadow stages become bubbles (rf_en=0, load=0, rd=0).
  - stall_count=0.
  - Outputs then follow the combinational rules below: SS=0, LE_*=1, flush=0, fwd_*=00.
- Valid-match rule: a stage "matches" source X when stage.rf_en=1, stage.rd==X, X's used bit is 1, and X!=15. R15/PC is never forwarded or stalled on.
- Load-use stall (combinational, same cycle): EX.load=1 and EX matches any used source -> SS=1, LE_PC=0, LE_IF_ID=0.
- Freeze (mem_busy=1):
  - LE_PC=0, LE_IF_ID=0, LE_pipe=0 and SS=0; the shadow stages hold.
  - stall_count does not increment.
  - Freeze dominates load-use stall.
- Shadow advance on a clock edge with mem_busy=0:
  - WB<=MEM and MEM<=EX.
  - EX<=bubble if SS=1, else {id_rd, id_RF_enable, id_load_instr}.
  - If flush_IF_ID was asserted, the ID instruction still advances, because the branch itself is valid.
- Forwarding, per operand, priority EX > MEM > WB; first match wins, else 00.
  - EX forwarding is never selected for a load; that case is covered by the stall.
  - While SS=1, the fwd outputs are don't-care but must still follow the rule.
- Branch: flush_IF_ID = id_branch_taken & ~SS & ~mem_busy.
  - A stalled branch flushes in the cycle it is finally accepted, so each taken branch produces exactly one flush cycle.
- stall_count increments on each clock edge where SS=1. It saturates at all-ones and never wraps.
- Latency:
  - SS and forwarding are combinational from the inputs and shadow state.
  - A load-use stall lasts exactly 1 cycle, then MEM forwarding selects the load data.
- Back-to-back loads are each checked independently.
- Reset mid-stall: outputs return to their defaults immediately, asynchronously.

Decomposition:
- Shared package:
  - REG_PC = 4'd15.
  - FWD_RF / FWD_EX / FWD_MEM / FWD_WB encodings.
  - stage_info typedef {rd, rf_en, load}.
- One natural sub-module: fwd_select, the per-operand priority match, instantiated 3 times (A, B, C).

Test Plan:
- Reset: rst_n=0 mid-run -> SS=0, LE_PC=LE_IF_ID=LE_pipe=1, fwd_*=00, stall_count=0.
- ALU chain: ADD R3 then SUB with Rn=R3 -> fwd_A=01 the next cycle, SS=0; one cycle later, with an unrelated instruction in between, fwd_A=10; then 11.
- Load-use: LDR R2 followed by ADD Rm=R2 -> SS=1, LE_PC=0, LE_IF_ID=0 for exactly 1 cycle, then fwd_B=10 and stall_count=1.
- Priority and PC:
  - R5 written in EX and in MEM, ID reads Rn=R5 -> fwd_A=01.
  - Any writer of R15 -> fwd=00, SS=0.
- Freeze vs branch:
  - mem_busy=1 with a load-use hazard and id_branch_taken=1 -> LE_*=0, SS=0, flush=0, shadow held.
  - Release mem_busy -> SS=1, flush=0; next cycle flush=1 once.
- Saturation: force 2^CNT_W+3 stall cycles (CNT_W=4 build: 19) -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and encodings for the ID-stage hazard/stall unit:
// shadow-stage record, forwarding-select codes and the source-match rule.
package hazard_stall_unit_pkg;

    localparam int RS_W = 4;

    // R15 is the PC; it is never forwarded and never causes a stall.
    localparam logic [RS_W-1:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic [RS_W-1:0] rd;
        logic            rf_en;
        logic            load;
    } stage_info;

    localparam stage_info BUBBLE = '{rd: '0, rf_en: 1'b0, load: 1'b0};

    function automatic logic stage_matches(
        input stage_info       s,
        input logic [RS_W-1:0] src,
        input logic            used
    );
        return s.rf_en && used && (s.rd == src) && (src != REG_PC);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_fwd_select.sv
// Per-operand forwarding priority (EX > MEM > WB) and load-use detection
// against the shadow EX stage.
module fwd_select
    import hazard_stall_unit_pkg::*;
(
    input  logic [RS_W-1:0] src,
    input  logic            used,
    input  stage_info       ex,
    input  stage_info       mem,
    input  stage_info       wb,
    output logic [1:0]      fwd_sel,
    output logic            load_hit
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        ex_hit   = stage_matches(ex, src, used);
        mem_hit  = stage_matches(mem, src, used);
        wb_hit   = stage_matches(wb, src, used);
        load_hit = ex_hit && ex.load;

        // A load in EX has no data yet; skip it and let the stall cover it.
        fwd_sel = FWD_RF;
        if (ex_hit && !ex.load) begin
            fwd_sel = FWD_EX;
        end else if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard unit: load-use stall, pipeline freeze, branch flush and
// operand forwarding, driven by a private shadow of the EX/MEM/WB destinations.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W = RS_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             id_rd_used,
    input  logic             id_RF_enable,
    input  logic             id_load_instr,
    input  logic             id_branch_taken,
    input  logic             mem_busy,
    output logic             SS,
    output logic             LE_PC,
    output logic             LE_IF_ID,
    output logic             LE_pipe,
    output logic             flush_IF_ID,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       fwd_C,
    output logic [CNT_W-1:0] stall_count
);

    stage_info        ex_q, ex_d;
    stage_info        mem_q, mem_d;
    stage_info        wb_q, wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic hit_a, hit_b, hit_c;
    logic load_use;
    logic ss;

    fwd_select u_fwd_a (
        .src      (id_rn),
        .used     (id_rn_used),
        .ex       (ex_q),
        .mem      (mem_q),
        .wb       (wb_q),
        .fwd_sel  (fwd_A),
        .load_hit (hit_a)
    );

    fwd_select u_fwd_b (
        .src      (id_rm),
        .used     (id_rm_used),
        .ex       (ex_q),
        .mem      (mem_q),
        .wb       (wb_q),
        .fwd_sel  (fwd_B),
        .load_hit (hit_b)
    );

    fwd_select u_fwd_c (
        .src      (id_rd),
        .used     (id_rd_used),
        .ex       (ex_q),
        .mem      (mem_q),
        .wb       (wb_q),
        .fwd_sel  (fwd_C),
        .load_hit (hit_c)
    );

    // Freeze dominates: while memory is busy nothing is inserted or flushed.
    always_comb begin
        load_use    = hit_a || hit_b || hit_c;
        ss          = load_use && !mem_busy;
        SS          = ss;
        LE_PC       = !mem_busy && !load_use;
        LE_IF_ID    = !mem_busy && !load_use;
        LE_pipe     = !mem_busy;
        flush_IF_ID = id_branch_taken && !ss && !mem_busy;
        stall_count = stall_count_q;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        stall_count_d = stall_count_q;

        if (!mem_busy) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (ss) begin
                ex_d = BUBBLE;
            end else begin
                ex_d.rd    = id_rd;
                ex_d.rf_en = id_RF_enable;
                ex_d.load  = id_load_instr;
            end
        end

        if (ss && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= BUBBLE;
            mem_q         <= BUBBLE;
            wb_q          <= BUBBLE;
            stall_count_q <= '0;
        end else begin
            // NOTE: non-blocking so all stages shift from the pre-edge values.
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a list-of-stages reference model checked
// every cycle, plus hand-computed literal checks for each scenario.
module tb_hazard_stall_unit;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic [3:0]          id_rn, id_rm, id_rd;
    logic                id_rn_used, id_rm_used, id_rd_used;
    logic                id_RF_enable, id_load_instr, id_branch_taken, mem_busy;
    logic                SS, LE_PC, LE_IF_ID, LE_pipe, flush_IF_ID;
    logic [1:0]          fwd_A, fwd_B, fwd_C;
    logic [TB_CNT_W-1:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_stall_unit #(.REG_W(4), .CNT_W(TB_CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_rd           (id_rd),
        .id_rn_used      (id_rn_used),
        .id_rm_used      (id_rm_used),
        .id_rd_used      (id_rd_used),
        .id_RF_enable    (id_RF_enable),
        .id_load_instr   (id_load_instr),
        .id_branch_taken (id_branch_taken),
        .mem_busy        (mem_busy),
        .SS              (SS),
        .LE_PC           (LE_PC),
        .LE_IF_ID        (LE_IF_ID),
        .LE_pipe         (LE_pipe),
        .flush_IF_ID     (flush_IF_ID),
        .fwd_A           (fwd_A),
        .fwd_B           (fwd_B),
        .fwd_C           (fwd_C),
        .stall_count     (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB (the three older instructions).
    logic [3:0] m_rd [3];
    bit         m_en [3];
    bit         m_ld [3];
    int         m_cnt;

    function automatic bit m_match(input int s, input logic [3:0] src, input logic used);
        return m_en[s] && used && (m_rd[s] == src) && (src != 4'd15);
    endfunction

    function automatic bit m_hazard();
        return m_ld[0] && (m_match(0, id_rn, id_rn_used) || m_match(0, id_rm, id_rm_used) ||
                           m_match(0, id_rd, id_rd_used));
    endfunction

    function automatic bit m_ss();
        return m_hazard() && !mem_busy;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [3:0] src, input logic used);
        for (int s = 0; s < 3; s++) begin
            if (m_match(s, src, used) && !(s == 0 && m_ld[0])) return 2'(s + 1);
        end
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_rd[i] <= '0;
                m_en[i] <= 1'b0;
                m_ld[i] <= 1'b0;
            end
            m_cnt <= 0;
        end else if (!mem_busy) begin
            for (int i = 2; i > 0; i--) begin
                m_rd[i] <= m_rd[i-1];
                m_en[i] <= m_en[i-1];
                m_ld[i] <= m_ld[i-1];
            end
            if (m_ss()) begin
                m_rd[0] <= '0;
                m_en[0] <= 1'b0;
                m_ld[0] <= 1'b0;
                if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            end else begin
                m_rd[0] <= id_rd;
                m_en[0] <= id_RF_enable;
                m_ld[0] <= id_load_instr;
            end
        end
    end

    always @(negedge clk) begin
        check("SS", 32'(SS), 32'(m_ss()));
        check("LE_PC", 32'(LE_PC), 32'(!mem_busy && !m_hazard()));
        check("LE_IF_ID", 32'(LE_IF_ID), 32'(!mem_busy && !m_hazard()));
        check("LE_pipe", 32'(LE_pipe), 32'(!mem_busy));
        check("flush_IF_ID", 32'(flush_IF_ID), 32'(id_branch_taken && !m_ss() && !mem_busy));
        check("fwd_A", 32'(fwd_A), 32'(m_fwd(id_rn, id_rn_used)));
        check("fwd_B", 32'(fwd_B), 32'(m_fwd(id_rm, id_rm_used)));
        check("fwd_C", 32'(fwd_C), 32'(m_fwd(id_rd, id_rd_used)));
        check("stall_count", 32'(stall_count), 32'(m_cnt));
    end

    task automatic drive(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic rn_u, input logic rm_u, input logic rd_u,
                         input logic rf, input logic ld, input logic br, input logic busy);
        id_rn           = rn;
        id_rm           = rm;
        id_rd           = rd;
        id_rn_used      = rn_u;
        id_rm_used      = rm_u;
        id_rd_used      = rd_u;
        id_RF_enable    = rf;
        id_load_instr   = ld;
        id_branch_taken = br;
        mem_busy        = busy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_SS", 32'(SS), 0);
        check("rst_LE_PC", 32'(LE_PC), 1);
        check("rst_LE_pipe", 32'(LE_pipe), 1);
        check("rst_count", 32'(stall_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ALU chain: ADD R3; SUB Rn=R3; two more readers of R3.
        drive(1, 2, 3, 1, 1, 0, 1, 0, 0, 0); tick();
        drive(3, 0, 4, 1, 0, 0, 1, 0, 0, 0);
        check("alu_fwdA_ex", 32'(fwd_A), 1);
        check("alu_ss", 32'(SS), 0);
        tick();
        drive(3, 0, 5, 1, 0, 0, 1, 0, 0, 0);
        check("alu_fwdA_mem", 32'(fwd_A), 2);
        tick();
        drive(3, 0, 6, 1, 0, 0, 1, 0, 0, 0);
        check("alu_fwdA_wb", 32'(fwd_A), 3);
        tick();
        drive(3, 0, 7, 1, 0, 0, 1, 0, 0, 0);
        check("alu_fwdA_rf", 32'(fwd_A), 0);
        tick();

        // Load-use: LDR R2,[R1]; ADD R9,R0,R2.
        drive(1, 0, 2, 1, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 2, 9, 1, 1, 0, 1, 0, 0, 0);
        check("lu_ss", 32'(SS), 1);
        check("lu_le_pc", 32'(LE_PC), 0);
        check("lu_le_ifid", 32'(LE_IF_ID), 0);
        check("lu_le_pipe", 32'(LE_pipe), 1);
        tick();
        check("lu_ss_after", 32'(SS), 0);
        check("lu_fwdB_mem", 32'(fwd_B), 2);
        check("lu_count", 32'(stall_count), 1);
        check("lu_le_pc_after", 32'(LE_PC), 1);
        tick();

        // Unused source register never stalls.
        drive(1, 0, 2, 1, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 2, 9, 1, 0, 0, 1, 0, 0, 0);
        check("unused_ss", 32'(SS), 0);
        tick();

        // Priority: R5 written in EX and MEM.
        drive(0, 0, 5, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 5, 0, 0, 0, 1, 0, 0, 0); tick();
        drive(5, 5, 5, 1, 1, 1, 0, 0, 0, 0);
        check("prio_fwdA", 32'(fwd_A), 1);
        check("prio_fwdB", 32'(fwd_B), 1);
        check("prio_fwdC", 32'(fwd_C), 1);
        tick();

        // R15 writer (a load) never forwards or stalls.
        drive(0, 0, 15, 0, 0, 0, 1, 1, 0, 0); tick();
        drive(15, 15, 15, 1, 1, 1, 0, 0, 0, 0);
        check("pc_ss", 32'(SS), 0);
        check("pc_fwdA", 32'(fwd_A), 0);
        check("pc_fwdC", 32'(fwd_C), 0);
        tick();

        // Freeze vs branch with a pending load-use hazard.
        drive(1, 0, 6, 1, 0, 0, 1, 1, 0, 0); tick();
        drive(6, 0, 8, 1, 0, 0, 1, 0, 1, 1);
        check("frz_le_pc", 32'(LE_PC), 0);
        check("frz_le_ifid", 32'(LE_IF_ID), 0);
        check("frz_le_pipe", 32'(LE_pipe), 0);
        check("frz_ss", 32'(SS), 0);
        check("frz_flush", 32'(flush_IF_ID), 0);
        tick();
        check("frz_count_held", 32'(stall_count), 1);
        drive(6, 0, 8, 1, 0, 0, 1, 0, 1, 0);
        check("rel_ss", 32'(SS), 1);
        check("rel_flush", 32'(flush_IF_ID), 0);
        tick();
        check("br_flush", 32'(flush_IF_ID), 1);
        check("br_ss", 32'(SS), 0);
        check("br_fwdA", 32'(fwd_A), 2);
        check("br_count", 32'(stall_count), 2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("br_flush_once", 32'(flush_IF_ID), 0);
        tick();

        // Asynchronous reset in the middle of a stall.
        drive(1, 0, 2, 1, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 2, 9, 0, 1, 0, 1, 0, 0, 0);
        check("mid_ss", 32'(SS), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ss", 32'(SS), 0);
        check("mid_rst_le_pc", 32'(LE_PC), 1);
        check("mid_rst_le_ifid", 32'(LE_IF_ID), 1);
        check("mid_rst_fwdB", 32'(fwd_B), 0);
        check("mid_rst_count", 32'(stall_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Saturation: LDR R2,[R2] repeated stalls every other cycle.
        for (int i = 0; i < 45; i++) begin
            drive(2, 0, 2, 1, 0, 0, 1, 1, 0, 0);
            tick();
        end
        check("sat_count", 32'(stall_count), 15);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
